if_fetch_queue: RTL and testbench

//  Instruction-fetch front end: the producer side of the IF->ID interface that id_stage consumes.
//  - Holds the PC and issues in-order requests to instruction memory.
//  - Buffers returned instructions in a small FIFO and hands {pc, instr} to decode over valid/ready.
//  - Services branch/jump redirects: flushes the queue and discards in-flight responses.

---
 rtl/if_fetch_queue.sv | 109 ++++++++++
 tb/tb_if_fetch_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end: PC, in-order imem requests, fetch queue to decode
// Optional same-cycle response bypass to decode when IF_BYPASS_EN is defined.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   input  logic        id_ready
);
   localparam int AW = $clog2(FQ_DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FQ_DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(FQ_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   q_pc    [FQ_DEPTH];
   logic [31:0]   q_instr [FQ_DEPTH];
   logic [31:0]   tag_pc  [FQ_DEPTH];
   logic [AW-1:0] q_rd, q_wr, tag_rd, tag_wr;
   logic [AW:0]   q_cnt, outstanding, drop;
   logic          q_empty, accept, rsp_live, bypass, push, pop;

   always_comb begin
      q_empty        = (q_cnt == '0);
      // credit: every in-flight request must have a queue slot waiting for it
      imem_req_valid = !reset && !redirect_valid &&
                       (({1'b0, q_cnt} + {1'b0, outstanding}) < DEPTH_W);
      imem_req_addr  = pc;
      accept         = imem_req_valid && imem_req_ready;
      rsp_live       = imem_rsp_valid && (drop == '0) && !redirect_valid && !reset;
`ifdef IF_BYPASS_EN
      bypass         = rsp_live && q_empty;
`else
      bypass         = 1'b0;
`endif
      id_valid       = !reset && (!q_empty || bypass);
      id_pc          = bypass ? tag_pc[tag_rd] : q_pc[q_rd];
      id_instr       = bypass ? imem_rsp_data  : q_instr[q_rd];
      pop            = id_valid && id_ready && !q_empty;
      push           = rsp_live && !(bypass && id_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         q_rd        <= '0;
         q_wr        <= '0;
         q_cnt       <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding + (AW+1)'(accept) - (AW+1)'(imem_rsp_valid);
         if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            q_rd   <= '0;
            q_wr   <= '0;
            q_cnt  <= '0;
            tag_rd <= '0;
            tag_wr <= '0;
            // everything still in flight after this cycle belongs to the old path
            drop   <= outstanding - (AW+1)'(imem_rsp_valid);
         end else begin
            if (accept) begin
               pc     <= pc + 32'd4;
               tag_wr <= tag_wr + AW'(1);
            end
            if (imem_rsp_valid) begin
               if (drop != '0)
                  drop <= drop - (AW+1)'(1);
               else
                  tag_rd <= tag_rd + AW'(1);
            end
            if (push)
               q_wr <= q_wr + AW'(1);
            if (pop)
               q_rd <= q_rd + AW'(1);
            q_cnt <= q_cnt + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && !redirect_valid) begin
         if (accept)
            tag_pc[tag_wr] <= pc;
         if (push) begin
            q_pc[q_wr]    <= tag_pc[tag_rd];
            q_instr[q_wr] <= imem_rsp_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(push && q_cnt == DEPTH_C));
   end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed table plus randomized model check of if_fetch_queue
module tb_if_fetch_queue;
`ifdef IF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   if_fetch_queue dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
   );

   typedef struct {
      bit          rst, rdy, rv;
      logic [31:0] rdata;
      bit          redir;
      logic [31:0] rpc;
      bit          idr;
      bit          e_rq;
      logic [31:0] e_addr;
      bit          e_nb, e_b;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [31:0] rd, bit redir, logic [31:0] rpc, bit idr,
                               bit erq, logic [31:0] ea, bit enb, bit eb, logic [31:0] epc, logic [31:0] ei);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.redir = redir; v.rpc = rpc; v.idr = idr;
      v.e_rq = erq; v.e_addr = ea; v.e_nb = enb; v.e_b = eb; v.e_pc = epc; v.e_instr = ei;
      return v;
   endfunction

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
   endfunction

   task automatic drive(bit rst, bit rdy, bit rv, logic [31:0] rd, bit redir, logic [31:0] rpc, bit idr);
      reset = rst; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
      redirect_valid = redir; redirect_pc = rpc; id_ready = idr;
   endtask

   initial begin
      ent_t        exq[$];
      req_t        mq[$];
      logic [31:0] m_pc;
      int          epoch;

      drive(1, 0, 0, 0, 0, 0, 0);

      // fill/stall, redirect with drops, PC wrap, redirect-cycle rsp, bypass
      vt.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h0,0,0,0,0));
      vt.push_back(mk(0,1,1,32'hC0DE0000,0,0,0, 1,32'h4,0,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,1,32'hC0DE0004,0,0,0, 1,32'h8,1,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,1,32'hC0DE0008,0,0,0, 1,32'hC,1,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,1,32'hC0DE000C,0,0,0, 0,0,1,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,0,0,0,0,0,            0,0,1,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,0,0,0,0,1,            0,0,1,1,32'h0,32'hC0DE0000));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h10,1,1,32'h4,32'hC0DE0004));
      vt.push_back(mk(0,1,1,32'hC0DE0010,0,0,0, 0,0,1,1,32'h4,32'hC0DE0004));
      vt.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h4,0,0,0,0));
      vt.push_back(mk(0,1,0,0,1,32'h103,0,      0,0,0,0,0,0));
      vt.push_back(mk(0,1,1,32'hDEAD0000,0,0,0, 1,32'h100,0,0,0,0));
      vt.push_back(mk(0,0,1,32'hDEAD0004,0,0,0, 1,32'h104,0,0,0,0));
      vt.push_back(mk(0,0,1,32'hC0DE0100,0,0,0, 1,32'h104,0,1,32'h100,32'hC0DE0100));
      vt.push_back(mk(0,0,0,0,0,0,1,            1,32'h104,1,1,32'h100,32'hC0DE0100));
      vt.push_back(mk(0,1,0,0,1,32'hFFFFFFFF,0, 0,0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'hFFFFFFFC,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h0,0,0,0,0));
      vt.push_back(mk(0,1,1,32'hBAD00000,1,32'h200,0, 0,0,0,0,0,0));
      vt.push_back(mk(0,1,1,32'hBAD00004,0,0,0, 1,32'h200,0,0,0,0));
      vt.push_back(mk(0,0,1,32'hC0DE0200,0,0,0, 1,32'h204,0,1,32'h200,32'hC0DE0200));
      vt.push_back(mk(0,0,0,0,0,0,0,            1,32'h204,1,1,32'h200,32'hC0DE0200));
      vt.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,            1,32'h0,0,0,0,0));
      vt.push_back(mk(0,0,1,32'h00000013,0,0,1, 1,32'h4,0,1,32'h0,32'h00000013));
      vt.push_back(mk(0,0,0,0,0,0,0,            1,32'h4,1,0,32'h0,32'h00000013));
      vt.push_back(mk(1,0,0,0,0,0,0,            0,0,0,0,0,0));

      for (int i = 0; i < vt.size(); i++) begin
         bit eidv;
         @(negedge clk);
         drive(vt[i].rst, vt[i].rdy, vt[i].rv, vt[i].rdata, vt[i].redir, vt[i].rpc, vt[i].idr);
         #1;
         eidv = BYP ? vt[i].e_b : vt[i].e_nb;
         chk($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rq));
         if (vt[i].e_rq) chk($sformatf("row%0d req_addr", i), imem_req_addr, vt[i].e_addr);
         chk($sformatf("row%0d id_valid", i), 32'(id_valid), 32'(eidv));
         if (eidv) begin
            chk($sformatf("row%0d id_pc", i), id_pc, vt[i].e_pc);
            chk($sformatf("row%0d id_instr", i), id_instr, vt[i].e_instr);
         end
      end

      // randomized run against a transaction-level model
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      m_pc = 32'h0; epoch = 0;
      for (int c = 0; c < 3000; c++) begin
         bit          rv, redir, rdy, idr, live, e_rq, e_idv, acc;
         logic [31:0] rd, rpc, a;
         int          sz;
         ent_t        e;
         req_t        r;
         @(negedge clk);
         redir = ($urandom_range(15) == 0);
         rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         rdy   = ($urandom_range(3) != 0);
         idr   = ($urandom_range(2) != 0);
         rv    = 1'b0;
         rd    = $urandom;
         if (mq.size() > 0) begin
            if (mq[0].due <= c && $urandom_range(3) != 0) begin
               rv = 1'b1;
               rd = memfn(mq[0].addr);
            end
         end
         drive(0, rdy, rv, rd, redir, rpc, idr);
         #1;
         sz   = exq.size();
         e_rq = !redir && (sz + mq.size() < 4);
         live = 1'b0;
         if (rv) live = (mq[0].epoch == epoch) && !redir;
         e_idv = (sz > 0) || (BYP && live);
         chk("rnd req_valid", 32'(imem_req_valid), 32'(e_rq));
         if (e_rq) chk("rnd req_addr", imem_req_addr, m_pc);
         chk("rnd id_valid", 32'(id_valid), 32'(e_idv));
         if (e_idv) begin
            if (sz > 0) e = exq[0];
            else begin e.pc = mq[0].addr; e.instr = rd; end
            chk("rnd id_pc", id_pc, e.pc);
            chk("rnd id_instr", id_instr, e.instr);
         end
         acc = imem_req_valid && rdy;
         a   = imem_req_addr;
         @(posedge clk);
         if (e_idv && idr && sz > 0) void'(exq.pop_front());
         if (live && !(BYP && sz == 0 && idr)) begin
            e.pc = mq[0].addr; e.instr = rd;
            exq.push_back(e);
         end
         if (rv) void'(mq.pop_front());
         if (redir) begin
            exq.delete();
            epoch++;
            m_pc = {rpc[31:2], 2'b00};
         end else if (e_rq && rdy) begin
            m_pc = m_pc + 32'd4;
         end
         if (acc) begin
            r.addr = a; r.epoch = epoch; r.due = c + 1 + int'($urandom_range(2));
            mq.push_back(r);
         end
      end

      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
